// File: rtl/muntjac_fpu_unpack.sv
// muntjac_fpu_unpack
// Converts a packed IEEE-754 word into sign, unbiased signed exponent,
// hidden-bit-free significand and zero/inf/nan flags. Subnormals are
// normalised one bit per cycle, so the result never contains a subnormal.
// One word is held in flight, with valid/ready handshakes on both sides.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i / in_ready_o    input handshake
//   in_data_i                  packed word {sign, exponent field, fraction}
//   out_valid_o / out_ready_i  output handshake
//   sign_o, exponent_o         sign and unbiased signed exponent
//   significand_o              fraction below the implicit leading 1
//   is_zero_o, is_inf_o, is_nan_o  classification flags
module muntjac_fpu_unpack #(
    parameter int unsigned ExpWidth = 9,
    parameter int unsigned SigWidth = 23
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ExpWidth+SigWidth-1:0] in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       sign_o,
    output logic signed [ExpWidth-1:0] exponent_o,
    output logic [SigWidth-1:0]        significand_o,
    output logic                       is_zero_o,
    output logic                       is_inf_o,
    output logic                       is_nan_o
);

    localparam int W       = ExpWidth + SigWidth;
    localparam int BiasInt = (1 << (ExpWidth - 2)) - 1;

    localparam logic signed [ExpWidth-1:0] ExpBias    = ExpWidth'(BiasInt);
    localparam logic signed [ExpWidth-1:0] ExpSubInit = ExpWidth'(1 - BiasInt);
    localparam logic signed [ExpWidth-1:0] ExpOne     = ExpWidth'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                       r_sign;
    logic signed [ExpWidth-1:0] r_exp;
    logic [SigWidth-1:0]        r_sig;
    logic                       r_zero;
    logic                       r_inf;
    logic                       r_nan;

    logic [ExpWidth-2:0] w_exp_fld;
    logic [SigWidth-1:0] w_frac;
    logic                w_exp_zero;
    logic                w_exp_ones;
    logic                w_frac_zero;
    logic                w_is_sub;
    logic                w_accept;

    assign w_exp_fld   = in_data_i[W-2:SigWidth];
    assign w_frac      = in_data_i[SigWidth-1:0];
    assign w_exp_zero  = (w_exp_fld == '0);
    assign w_exp_ones  = (w_exp_fld == '1);
    assign w_frac_zero = (w_frac == '0);
    assign w_is_sub    = w_exp_zero && !w_frac_zero;

    // Only out_ready_i reaches in_ready_o combinationally; this lets DONE
    // hand over to a new word in the same cycle the result is consumed.
    assign in_ready_o  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready_i);
    assign w_accept    = in_valid_i && in_ready_o;
    assign out_valid_o = (r_state == S_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_sub ? S_NORM : S_DONE;
                end
            end
            S_NORM: begin
                // The bit about to be shifted out is the leading 1 that
                // becomes the implicit bit, so normalisation ends here.
                if (r_sig[SigWidth-1]) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        w_state_nxt = w_is_sub ? S_NORM : S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_sig  <= '0;
            r_zero <= 1'b0;
            r_inf  <= 1'b0;
            r_nan  <= 1'b0;
        end else if (w_accept) begin
            r_sign <= in_data_i[W-1];
            r_zero <= 1'b0;
            r_inf  <= 1'b0;
            r_nan  <= 1'b0;
            if (w_exp_ones) begin
                // Inf and NaN share the all-ones field; NaN keeps its
                // payload (including the quiet bit) in the significand.
                r_exp  <= '0;
                r_sig  <= w_frac;
                r_inf  <= w_frac_zero;
                r_nan  <= !w_frac_zero;
            end else if (w_exp_zero) begin
                // Zero finishes directly; a subnormal starts at the
                // minimum normal exponent and is walked down in NORM.
                r_exp  <= w_frac_zero ? '0 : ExpSubInit;
                r_sig  <= w_frac;
                r_zero <= w_frac_zero;
            end else begin
                r_exp  <= signed'({1'b0, w_exp_fld}) - ExpBias;
                r_sig  <= w_frac;
            end
        end else if (r_state == S_NORM) begin
            r_sig <= {r_sig[SigWidth-2:0], 1'b0};
            r_exp <= r_exp - ExpOne;
        end
    end

    assign sign_o        = r_sign;
    assign exponent_o    = r_exp;
    assign significand_o = r_sig;
    assign is_zero_o     = r_zero;
    assign is_inf_o      = r_inf;
    assign is_nan_o      = r_nan;

endmodule

// File: tb/tb_muntjac_fpu_unpack.sv
// Testbench for muntjac_fpu_unpack (single precision). A transaction-level
// reference model predicts every field from the IEEE-754 rules with plain
// arithmetic; a one-entry scoreboard predicts handshake behaviour each cycle.
module tb_muntjac_fpu_unpack;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              sign_o;
    logic signed [8:0] exponent_o;
    logic [22:0]       significand_o;
    logic              is_zero_o;
    logic              is_inf_o;
    logic              is_nan_o;

    always #5 clk = ~clk;

    muntjac_fpu_unpack #(.ExpWidth(9), .SigWidth(23)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .sign_o       (sign_o),
        .exponent_o   (exponent_o),
        .significand_o(significand_o),
        .is_zero_o    (is_zero_o),
        .is_inf_o     (is_inf_o),
        .is_nan_o     (is_nan_o)
    );

    typedef struct {
        logic sign;
        int   exp;
        int   sig;
        logic z;
        logic inf;
        logic nan;
        int   lat;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;

    // scoreboard: at most one word in flight
    logic have = 1'b0;
    exp_t cur;
    int   age  = 0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w);
        exp_t m;
        int e, f, p, k;
        e = int'(w[30:23]);
        f = int'(w[22:0]);
        m.sign = w[31];
        m.exp = 0; m.sig = 0; m.z = 0; m.inf = 0; m.nan = 0; m.lat = 1;
        if (e == 255) begin
            if (f == 0) m.inf = 1;
            else begin m.nan = 1; m.sig = f; end
        end else if (e == 0) begin
            if (f == 0) m.z = 1;
            else begin
                p = 22;
                while (((f >> p) & 1) == 0) p--;
                k = 23 - p;
                m.exp = 1 - 127 - k;
                m.sig = (f << k) & 32'h7FFFFF;
                m.lat = 1 + k;
            end
        end else begin
            m.exp = e - 127;
            m.sig = f;
        end
        return m;
    endfunction

    task automatic chk_fields(input string tag, input exp_t m);
        chk({tag, ".sign"}, sign_o, m.sign);
        chk({tag, ".exp"}, $signed(exponent_o), m.exp);
        chk({tag, ".sig"}, significand_o, m.sig);
        chk({tag, ".zero"}, is_zero_o, m.z);
        chk({tag, ".inf"}, is_inf_o, m.inf);
        chk({tag, ".nan"}, is_nan_o, m.nan);
    endtask

    // One clock cycle: drive inputs, predict and check handshakes, then advance.
    task automatic step(input logic v, input logic [31:0] d, input logic r);
        logic ev, er;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        #1;
        ev = have && (age >= cur.lat);
        er = !have || (ev && r);
        chk("out_valid", out_valid_o, ev);
        chk("in_ready", in_ready_o, er);
        if (ev && r) begin
            chk_fields("sb", cur);
            have = 1'b0;
        end
        if (v && er) begin
            cur  = model(d);
            have = 1'b1;
            age  = 0;
        end
        @(posedge clk);
        #1;
        if (have) age++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        in_data_i = 32'h0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        have  = 1'b0;
        age   = 0;
        chk("rst.out_valid", out_valid_o, 0);
        chk("rst.in_ready", in_ready_o, 1);
        chk("rst.sign", sign_o, 0);
        chk("rst.exp", $signed(exponent_o), 0);
        chk("rst.sig", significand_o, 0);
        chk("rst.flags", {is_zero_o, is_inf_o, is_nan_o}, 0);
    endtask

    // Accept one word from IDLE, wait (bounded) for the result, check latency
    // and plan-level values, then consume it.
    task automatic run_word(input logic [31:0] w, input int lat, input logic s,
                            input int e, input int sg, input logic [2:0] flg);
        int cnt;
        step(1'b1, w, 1'b0);
        cnt = 1;
        while (!out_valid_o && cnt < 40) begin
            step(1'b0, 32'h0, 1'b0);
            cnt++;
        end
        chk("latency", cnt, lat);
        chk("plan.sign", sign_o, s);
        chk("plan.exp", $signed(exponent_o), e);
        chk("plan.sig", significand_o, sg);
        chk("plan.flags", {is_zero_o, is_inf_o, is_nan_o}, flg);
        step(1'b0, 32'h0, 1'b1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int f;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[30:23] = 8'h00;
            1: begin w[30:23] = 8'hFF; w[22:0] = '0; end
            2: w[30:23] = 8'hFF;
            3: begin
                f = $urandom_range(1, 32'h7FFFFF) >> $urandom_range(0, 22);
                if (f == 0) f = 1;
                w[30:23] = 8'h00;
                w[22:0]  = f[22:0];
            end
            4: w[30:0] = '0;
            default: ;
        endcase
        return w;
    endfunction

    logic [31:0] b2b [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        in_data_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // normal and special values
        run_word(32'h3F800000, 1, 0, 0, 0, 3'b000);
        run_word(32'h7F7FFFFF, 1, 0, 127, 32'h7FFFFF, 3'b000);
        run_word(32'h80000000, 1, 1, 0, 0, 3'b100);
        run_word(32'hFF800000, 1, 1, 0, 0, 3'b010);
        run_word(32'h7FA00000, 1, 0, 0, 32'h200000, 3'b001);
        run_word(32'h7FC00000, 1, 0, 0, 32'h400000, 3'b001);

        // subnormals
        run_word(32'h00400000, 2, 0, -127, 0, 3'b000);
        run_word(32'h00000001, 24, 0, -149, 0, 3'b000);
        run_word(32'h00000003, 23, 0, -148, 32'h400000, 3'b000);

        // backpressure, then same-cycle handover to a new word
        step(1'b1, 32'h40000000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp.exp", $signed(exponent_o), 1);
            chk("bp.in_ready", in_ready_o, 0);
            step(1'b0, 32'h0, 1'b0);
        end
        step(1'b1, 32'hC0400000, 1'b1);
        chk("bp.new.sign", sign_o, 1);
        chk("bp.new.exp", $signed(exponent_o), 1);
        chk("bp.new.sig", significand_o, 32'h400000);
        step(1'b0, 32'h0, 1'b1);

        // back-to-back stream of normal words
        for (int i = 0; i < 8; i++) begin
            b2b[i] = $urandom;
            b2b[i][30:23] = 8'($urandom_range(1, 254));
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, b2b[i], 1'b1);
            chk("b2b.valid", out_valid_o, 1);
            chk_fields("b2b", model(b2b[i]));
        end
        step(1'b0, 32'h0, 1'b1);

        // reset during the 5th NORM cycle
        step(1'b1, 32'h00000001, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
        do_reset();
        run_word(32'h3F800000, 1, 0, 0, 0, 3'b000);

        // randomized traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), rand_word(), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
